// File: rtl/pipe_hazard_if.sv
// Pipeline-to-hazard-controller signal bundle.
// The pipeline drives the hazard sources. The controller drives the stall/flush controls and status.
interface pipe_hazard_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_regread1;
  logic        ID_regread2;
  logic        EX_memread;
  logic [4:0]  EX_wraddr;
  logic        EX_redirect;
  logic        EX_md_start;
  logic        MEM_memreq;
  logic        mem_ready;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_stall;
  logic        idex_flush;
  logic        exmem_stall;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        md_busy;
  logic        md_done;
  logic        mem_err;
  logic [31:0] stall_cnt;

  modport master (
    output ID_rs, ID_rt, ID_regread1, ID_regread2, EX_memread, EX_wraddr,
           EX_redirect, EX_md_start, MEM_memreq, mem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, exmem_flush, memwb_flush, md_busy, md_done,
           mem_err, stall_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_regread1, ID_regread2, EX_memread, EX_wraddr,
           EX_redirect, EX_md_start, MEM_memreq, mem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, exmem_flush, memwb_flush, md_busy, md_done,
           mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// state  | meaning
// RUN    | normal issue; hazards resolved per cycle
// MDBUSY | mul/div occupying EX; front end frozen, EX/MEM bubbled
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_hazard_if.slave hz
);

  typedef enum logic {RUN = 1'b0, MDBUSY = 1'b1} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   md_cnt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [31:0]        stall_cnt;
  logic               mem_err;

  logic mem_hold, mem_timeout, load_use, md_stall;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exmem_stall, exmem_flush, memwb_flush, md_busy, md_done;

  assign mem_timeout = hz.MEM_memreq & ~hz.mem_ready & (wait_cnt == CNT_W'(MEM_TIMEOUT));
  assign mem_hold    = hz.MEM_memreq & ~hz.mem_ready & (wait_cnt != CNT_W'(MEM_TIMEOUT));
  assign load_use    = hz.EX_memread & (hz.EX_wraddr != 5'd0) &
                       ((hz.ID_regread1 & (hz.ID_rs == hz.EX_wraddr)) |
                        (hz.ID_regread2 & (hz.ID_rt == hz.EX_wraddr)));
  assign md_stall    = (state == MDBUSY) | hz.EX_md_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    if (rst_n) begin
      md_busy = (state == MDBUSY);
      md_done = (state == MDBUSY) && (md_cnt == '0) && !mem_hold;
      case (state)
        RUN:     if (hz.EX_md_start && !mem_hold) state_next = MDBUSY;
        MDBUSY:  if (md_done) state_next = RUN;
        default: state_next = RUN;
      endcase
      // Memory wait freezes everything up to EX, so redirects/load-use wait their turn.
      if (mem_hold) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else if (md_stall) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_flush = 1'b1;
      end else if (hz.EX_redirect) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_flush  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (state == RUN) begin
      if (hz.EX_md_start && !mem_hold) md_cnt <= CNT_W'(MD_LATENCY - 2);
    end else if (!mem_hold && md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      wait_cnt <= mem_hold ? wait_cnt + 1'b1 : '0;
      if (mem_timeout) mem_err <= 1'b1;
      if (pc_stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = ifid_stall;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_stall  = idex_stall;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_stall = exmem_stall;
  assign hz.exmem_flush = exmem_flush;
  assign hz.memwb_flush = memwb_flush;
  assign hz.md_busy     = md_busy;
  assign hz.md_done     = md_done;
  assign hz.mem_err     = mem_err;
  assign hz.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int MD_LAT = 4;
  localparam int MTO    = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_hazard_if hz ();

  pipe_hazard_ctrl #(.MD_LATENCY(MD_LAT), .MEM_TIMEOUT(MTO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining mul/div busy cycles, consecutive wait cycles, error flag, stall count.
  bit          m_md_active = 0;
  int          m_md_left   = 0;
  int          m_waited    = 0;
  bit          m_err       = 0;
  logic [31:0] m_scnt      = '0;

  always @(negedge clk) begin
    logic [9:0] exp_v, act_v;
    bit hold, tmo, lu, done_e;
    act_v = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall, hz.idex_flush,
             hz.exmem_stall, hz.exmem_flush, hz.memwb_flush, hz.md_busy, hz.md_done};
    if (!rst_n) begin
      m_md_active = 0; m_md_left = 0; m_waited = 0; m_err = 0; m_scnt = '0;
      chk("rst_comb", 32'(act_v), 32'd0);
      chk("rst_err", 32'(hz.mem_err), 32'd0);
      chk("rst_cnt", hz.stall_cnt, 32'd0);
    end else begin
      hold = hz.MEM_memreq && !hz.mem_ready && (m_waited < MTO);
      tmo  = hz.MEM_memreq && !hz.mem_ready && (m_waited == MTO);
      lu   = hz.EX_memread && hz.EX_wraddr != 0 &&
             ((hz.ID_regread1 && hz.ID_rs == hz.EX_wraddr) ||
              (hz.ID_regread2 && hz.ID_rt == hz.EX_wraddr));
      done_e = m_md_active && m_md_left == 1 && !hold;
      // bit order: pc ifid_s ifid_f idex_s idex_f exmem_s exmem_f memwb_f busy done
      if (hold)                                exp_v = 10'b1101010100;
      else if (m_md_active || hz.EX_md_start)  exp_v = 10'b1101001000;
      else if (hz.EX_redirect)                 exp_v = 10'b0010100000;
      else if (lu)                             exp_v = 10'b1100100000;
      else                                     exp_v = 10'b0000000000;
      exp_v[1] = m_md_active;
      exp_v[0] = done_e;
      chk("comb_outputs", 32'(act_v), 32'(exp_v));
      chk("mem_err", 32'(hz.mem_err), 32'(m_err));
      chk("stall_cnt", hz.stall_cnt, m_scnt);
      if (exp_v[9]) m_scnt = m_scnt + 32'd1;
      if (tmo) m_err = 1;
      m_waited = hold ? m_waited + 1 : 0;
      if (m_md_active) begin
        if (!hold) begin
          if (m_md_left == 1) m_md_active = 0;
          else m_md_left--;
        end
      end else if (hz.EX_md_start && !hold) begin
        m_md_active = 1;
        m_md_left   = MD_LAT - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz.ID_rs = 5'd0; hz.ID_rt = 5'd0; hz.ID_regread1 = 1'b0; hz.ID_regread2 = 1'b0;
    hz.EX_memread = 1'b0; hz.EX_wraddr = 5'd0; hz.EX_redirect = 1'b0;
    hz.EX_md_start = 1'b0; hz.MEM_memreq = 1'b0; hz.mem_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] s0;
    int freezes, dones;
    bit slow;
    clr();
    rst_n = 1'b0;
    hz.EX_md_start = 1'b1; hz.MEM_memreq = 1'b1;
    #2;
    chk("reset_pc_stall", 32'(hz.pc_stall), 32'd0);
    chk("reset_memwb_flush", 32'(hz.memwb_flush), 32'd0);
    tick(); tick();
    clr(); rst_n = 1'b1;
    #1;
    chk("post_reset_cnt", hz.stall_cnt, 32'd0);

    // load-use
    tick(); clr();
    hz.EX_memread = 1'b1; hz.EX_wraddr = 5'd2; hz.ID_rs = 5'd2; hz.ID_regread1 = 1'b1;
    #1;
    chk("lu_stall", {29'd0, hz.pc_stall, hz.ifid_stall, hz.idex_flush}, 32'd7);
    tick(); clr();
    #1;
    chk("lu_release", 32'(hz.pc_stall), 32'd0);
    chk("lu_cnt", hz.stall_cnt, 32'd1);

    tick(); clr();
    hz.EX_memread = 1'b1; hz.EX_wraddr = 5'd0; hz.ID_rs = 5'd0; hz.ID_regread1 = 1'b1;
    #1;
    chk("lu_r0", 32'(hz.pc_stall), 32'd0);
    tick(); clr();
    hz.EX_memread = 1'b1; hz.EX_wraddr = 5'd2; hz.ID_rs = 5'd2; hz.ID_regread1 = 1'b0;
    #1;
    chk("lu_noread", {31'd0, hz.pc_stall | hz.idex_flush}, 32'd0);

    tick(); clr();
    hz.EX_memread = 1'b1; hz.EX_wraddr = 5'd3; hz.ID_rt = 5'd3; hz.ID_regread2 = 1'b1;
    hz.EX_redirect = 1'b1;
    #1;
    chk("redirect_over_lu", {28'd0, hz.ifid_flush, hz.idex_flush, hz.pc_stall, hz.idex_stall}, 32'hC);

    // mul/div: issue cycle plus three busy cycles
    tick(); clr();
    s0 = hz.stall_cnt;
    dones = 0;
    hz.EX_md_start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin tick(); clr(); end
      #1;
      chk("md_stall", {30'd0, hz.pc_stall, hz.exmem_flush}, 32'd3);
      chk("md_done_cycle", 32'(hz.md_done), (k == 4) ? 32'd1 : 32'd0);
      dones += int'(hz.md_done);
    end
    tick(); clr();
    #1;
    chk("md_back_run", {30'd0, hz.md_busy, hz.pc_stall}, 32'd0);
    chk("md_cnt_plus4", hz.stall_cnt, s0 + 32'd4);
    chk("md_done_once", 32'(dones), 32'd1);

    // five wait cycles then ready
    for (int k = 0; k < 5; k++) begin
      tick(); clr();
      hz.MEM_memreq = 1'b1;
      #1;
      chk("wait_freeze", {29'd0, hz.pc_stall, hz.exmem_stall, hz.memwb_flush}, 32'd7);
    end
    tick(); clr();
    hz.MEM_memreq = 1'b1; hz.mem_ready = 1'b1;
    #1;
    chk("wait_release", {30'd0, hz.pc_stall, hz.memwb_flush}, 32'd0);

    // timeout: eight freezes then a forced release
    freezes = 0;
    for (int k = 1; k <= 9; k++) begin
      tick(); clr();
      hz.MEM_memreq = 1'b1;
      #1;
      freezes += int'(hz.memwb_flush);
      if (k == 9) chk("timeout_release", 32'(hz.memwb_flush), 32'd0);
    end
    chk("timeout_freezes", 32'(freezes), 32'd8);
    tick(); clr();
    #1;
    chk("mem_err_set", 32'(hz.mem_err), 32'd1);
    tick(); tick();
    chk("mem_err_sticky", 32'(hz.mem_err), 32'd1);

    // reset during MDBUSY
    tick(); clr(); hz.EX_md_start = 1'b1;
    tick(); clr();
    #1;
    chk("in_mdbusy", 32'(hz.md_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_md", {30'd0, hz.pc_stall, hz.md_busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_md_after", {31'd0, hz.md_busy}, 32'd0);
    chk("rst_cnt_after", hz.stall_cnt, 32'd0);
    chk("rst_err_after", 32'(hz.mem_err), 32'd0);

    // random traffic
    slow = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 49) == 0) slow = ~slow;
      rst_n = ($urandom_range(0, 299) != 0);
      hz.ID_rs       = 5'($urandom_range(0, 3));
      hz.ID_rt       = 5'($urandom_range(0, 3));
      hz.ID_regread1 = ($urandom_range(0, 1) == 1);
      hz.ID_regread2 = ($urandom_range(0, 1) == 1);
      hz.EX_memread  = ($urandom_range(0, 2) == 0);
      hz.EX_wraddr   = 5'($urandom_range(0, 3));
      hz.EX_redirect = ($urandom_range(0, 7) == 0);
      hz.EX_md_start = ($urandom_range(0, 9) == 0);
      hz.MEM_memreq  = ($urandom_range(0, 3) == 0) || slow;
      hz.mem_ready   = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
    end
    tick(); clr(); rst_n = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
